// File: rtl/rhd_cmd_sequencer.sv
// rhd_cmd_sequencer: command-word sequencer for an RHD-style amplifier chip.
// Issues register init, calibration, then continuous CONVERT/aux frames.
module rhd_cmd_sequencer #(
    parameter int NUM_CH      = 32,
    parameter int CAL_DUMMIES = 9
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        stop,
    input  logic        fast_settle,
    input  logic [15:0] batch_len,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [7:0]  cfg_data,
    output logic [15:0] cmd_word,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic        frame_start,
    output logic        batch_done,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_CAL,
        S_RUN,
        S_STOP
    } state_t;

    localparam logic [7:0]  LAST_INIT = 8'd7;
    localparam logic [7:0]  LAST_CAL  = 8'(CAL_DUMMIES);
    localparam logic [7:0]  SLOT_WR   = 8'(NUM_CH);
    localparam logic [7:0]  SLOT_RD   = 8'(NUM_CH + 1);
    localparam logic [7:0]  SLOT_LAST = 8'(NUM_CH + 2);
    localparam logic [15:0] CMD_CAL   = 16'h5500;
    localparam logic [15:0] CMD_DUMMY = 16'hFF00;

    state_t      r_state;
    logic [7:0]  r_idx;
    logic [7:0]  r_shadow [8];
    logic        r_fs;
    logic [2:0]  r_aux;
    logic [15:0] r_frames;
    logic        r_stop_pend;
    logic [15:0] r_word;
    logic        r_valid;
    logic        r_frame_start;
    logic        r_batch_done;

    logic        w_hs;
    logic        w_stop_any;
    logic        w_frame_end;
    logic        w_batch_hit;
    logic        w_fs_eff;
    logic [15:0] w_len;
    logic [16:0] w_frames_inc;
    logic [5:0]  w_aux_reg;
    logic [7:0]  w_sh0;
    state_t      w_nstate;
    logic [7:0]  w_nidx;
    logic [15:0] w_nword;

    assign w_hs         = r_valid & cmd_ready;
    assign w_stop_any   = r_stop_pend | stop;
    assign w_len        = (batch_len == 16'd0) ? 16'd1 : batch_len;
    assign w_frames_inc = {1'b0, r_frames} + 17'd1;
    assign w_batch_hit  = (w_frames_inc >= {1'b0, w_len});
    assign w_aux_reg    = 6'd40 + {3'd0, r_aux};
    // slot 0 is being accepted now, so its fast_settle is not latched yet
    assign w_fs_eff     = (r_idx == 8'd0) ? fast_settle : r_fs;
    assign w_sh0        = {r_shadow[0][7:6], w_fs_eff, r_shadow[0][4:0]};

    always_comb begin
        w_nstate    = r_state;
        w_nidx      = r_idx;
        w_frame_end = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_idx == LAST_INIT) begin
                    w_nstate = S_CAL;
                    w_nidx   = 8'd0;
                end else begin
                    w_nidx = r_idx + 8'd1;
                end
            end
            S_CAL: begin
                if (r_idx == LAST_CAL) begin
                    w_nstate = S_RUN;
                    w_nidx   = 8'd0;
                end else begin
                    w_nidx = r_idx + 8'd1;
                end
            end
            S_RUN: begin
                if (r_idx == SLOT_LAST) begin
                    w_frame_end = 1'b1;
                    w_nidx      = 8'd0;
                    if (w_stop_any) begin
                        w_nstate = S_STOP;
                    end
                end else begin
                    w_nidx = r_idx + 8'd1;
                end
            end
            default: begin
                w_nstate = r_state;
            end
        endcase
    end

    always_comb begin
        w_nword = 16'h0000;
        case (w_nstate)
            S_INIT: begin
                w_nword = {2'b10, w_nidx[5:0], r_shadow[w_nidx[2:0]]};
            end
            S_CAL: begin
                w_nword = (w_nidx == 8'd0) ? CMD_CAL : CMD_DUMMY;
            end
            S_RUN: begin
                unique case (1'b1)
                    (w_nidx < SLOT_WR):  w_nword = {2'b00, w_nidx[5:0], 8'h00};
                    (w_nidx == SLOT_WR): w_nword = {2'b10, 6'd0, w_sh0};
                    (w_nidx == SLOT_RD): w_nword = {2'b11, w_aux_reg, 8'h00};
                    default:             w_nword = CMD_DUMMY;
                endcase
            end
            default: begin
                w_nword = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 8; i++) begin
                r_shadow[i] <= 8'h00;
            end
        end else if (cfg_we) begin
            r_shadow[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state       <= S_IDLE;
            r_idx         <= 8'd0;
            r_fs          <= 1'b0;
            r_aux         <= 3'd0;
            r_frames      <= 16'd0;
            r_stop_pend   <= 1'b0;
            r_word        <= 16'h0000;
            r_valid       <= 1'b0;
            r_frame_start <= 1'b0;
            r_batch_done  <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_batch_done  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start && !stop) begin
                        r_state     <= S_INIT;
                        r_idx       <= 8'd0;
                        r_aux       <= 3'd0;
                        r_frames    <= 16'd0;
                        r_stop_pend <= 1'b0;
                        r_valid     <= 1'b1;
                        r_word      <= {2'b10, 6'd0, r_shadow[0]};
                    end
                end
                S_INIT, S_CAL, S_RUN: begin
                    if (stop) begin
                        r_stop_pend <= 1'b1;
                    end
                    if (w_hs) begin
                        r_state <= w_nstate;
                        r_idx   <= w_nidx;
                        r_word  <= w_nword;
                        r_valid <= (w_nstate != S_STOP);
                        if (r_state == S_RUN && r_idx == 8'd0) begin
                            r_fs          <= fast_settle;
                            r_frame_start <= 1'b1;
                        end
                        if (w_frame_end) begin
                            r_aux <= (r_aux == 3'd4) ? 3'd0 : r_aux + 3'd1;
                            if (w_batch_hit) begin
                                r_batch_done <= 1'b1;
                                r_frames     <= 16'd0;
                            end else begin
                                r_frames <= w_frames_inc[15:0];
                            end
                        end
                    end
                end
                S_STOP: begin
                    r_state     <= S_IDLE;
                    r_valid     <= 1'b0;
                    r_stop_pend <= 1'b0;
                    r_frames    <= 16'd0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_word    = r_word;
    assign cmd_valid   = r_valid;
    assign frame_start = r_frame_start;
    assign batch_done  = r_batch_done;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_rhd_cmd_sequencer.sv
// tb_rhd_cmd_sequencer: table vectors, directed corner sequences and
// randomized stall/config runs checked against a word-list model.
module tb_rhd_cmd_sequencer;

    localparam int NCH  = 32;
    localparam int NCAL = 9;
    localparam int PRE  = 8 + 1 + NCAL;
    localparam int FLEN = NCH + 3;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        fast_settle = 1'b0;
    logic [15:0] batch_len = 16'd8;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [7:0]  cfg_data = 8'd0;
    logic [15:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic        frame_start;
    logic        batch_done;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;
    logic [7:0]  sh [8];
    logic [15:0] got[$];
    logic [15:0] exp_q[$];
    int bd_at[$];
    int fr_at[$];

    typedef struct {
        logic        start;
        logic        stop;
        logic        ready;
        logic        we;
        logic [2:0]  addr;
        logic [7:0]  data;
        logic        busy;
        logic        valid;
        logic [15:0] word;
    } vec_t;
    vec_t tbl [16];

    always #5 aclk = ~aclk;

    rhd_cmd_sequencer #(.NUM_CH(NCH), .CAL_DUMMIES(NCAL)) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .start(start),
        .stop(stop),
        .fast_settle(fast_settle),
        .batch_len(batch_len),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .cmd_word(cmd_word),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .frame_start(frame_start),
        .batch_done(batch_done),
        .busy(busy)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg_we = 1'b0;
        cmd_ready = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 8; i++) sh[i] = 8'h00;
        @(negedge aclk);
    endtask

    task automatic cfg_write(int a, logic [7:0] d);
        cfg_we = 1'b1;
        cfg_addr = 3'(a);
        cfg_data = d;
        @(negedge aclk);
        cfg_we = 1'b0;
        sh[a] = d;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        got.delete();
        bd_at.delete();
        fr_at.delete();
    endtask

    // expected accepted-word list: init, calibration, then nfr frames
    task automatic build_exp(int nfr, logic [31:0] fs_bits);
        logic [7:0] w0;
        exp_q.delete();
        for (int r = 0; r < 8; r++) exp_q.push_back({2'b10, 6'(r), sh[r]});
        exp_q.push_back(16'h5500);
        for (int i = 0; i < NCAL; i++) exp_q.push_back(16'hFF00);
        for (int f = 0; f < nfr; f++) begin
            for (int c = 0; c < NCH; c++) exp_q.push_back(16'(c) << 8);
            w0 = (sh[0] & 8'hDF) | (fs_bits[f] ? 8'h20 : 8'h00);
            exp_q.push_back({8'h80, w0});
            exp_q.push_back(16'hC000 | (16'(40 + f % 5) << 8));
            exp_q.push_back(16'hFF00);
        end
    endtask

    task automatic cmp_stream(string name);
        int n;
        chk({name, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), got[i], exp_q[i]);
    endtask

    task automatic cmp_q(string name, int a[$], int b[$]);
        int n;
        chk({name, "_count"}, a.size(), b.size());
        n = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s[%0d]", name, i), a[i], b[i]);
    endtask

    task automatic cmp_pulses(string name, int len, int nfr);
        int eb[$];
        int ef[$];
        for (int f = 0; f < nfr; f++) begin
            ef.push_back(PRE + FLEN * f + 1);
            if ((f + 1) % len == 0) eb.push_back(PRE + FLEN * (f + 1));
        end
        cmp_q({name, "_bdone"}, bd_at, eb);
        cmp_q({name, "_fstart"}, fr_at, ef);
    endtask

    // accept n words, ready dropped with probability stall_pct percent
    task automatic collect(int n, int stall_pct);
        int k = 0;
        int guard = 0;
        bit stalled = 0;
        bit prev_hs = 0;
        logic [15:0] held = 16'h0;
        while (k < n && guard < 4 * n + 20) begin
            if (guard > 0) begin
                if (batch_done) bd_at.push_back(got.size());
                if (frame_start) fr_at.push_back(got.size());
            end
            if (stalled) begin
                chk("stall_word", cmd_word, held);
                chk("stall_valid", cmd_valid, 1'b1);
            end else if (prev_hs) begin
                chk("no_bubble", cmd_valid, 1'b1);
            end
            cmd_ready = (int'($urandom_range(0, 99)) >= stall_pct);
            prev_hs = 0;
            stalled = 0;
            if (cmd_valid && cmd_ready) begin
                got.push_back(cmd_word);
                k++;
                prev_hs = 1;
            end else if (cmd_valid) begin
                stalled = 1;
                held = cmd_word;
            end
            @(negedge aclk);
            guard++;
        end
        if (k < n) begin
            n_vec++;
            n_bad++;
            $display("FAIL collect_timeout: got %0d words, want %0d", k, n);
        end
        if (batch_done) bd_at.push_back(got.size());
        if (frame_start) fr_at.push_back(got.size());
    endtask

    // ready held high until the sequencer drops valid
    task automatic drain(output int n);
        int guard = 0;
        n = 0;
        cmd_ready = 1'b1;
        while (cmd_valid === 1'b1 && guard < 500) begin
            got.push_back(cmd_word);
            n++;
            @(negedge aclk);
            stop = 1'b0;
            guard++;
        end
        if (guard >= 500) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain_timeout: valid still 1 after %0d words", n);
        end
        stop = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int eb[$];
        logic fs;
        int len;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 1'b0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8000};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8000};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8100};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8200};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8200};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h83A5};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 8'h3C, 1'b1, 1'b1, 16'h8400};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 8'h77, 1'b1, 1'b1, 16'h8400};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8577};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8600};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h8700};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'h5500};
        tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 16'hFF00};

        do_reset();
        chk("rst_valid", cmd_valid, 1'b0);
        chk("rst_word", cmd_word, 16'h0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fstart", frame_start, 1'b0);
        chk("rst_bdone", batch_done, 1'b0);

        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            stop = tbl[i].stop;
            cmd_ready = tbl[i].ready;
            cfg_we = tbl[i].we;
            cfg_addr = tbl[i].addr;
            cfg_data = tbl[i].data;
            @(negedge aclk);
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            chk($sformatf("tbl%0d_valid", i), cmd_valid, tbl[i].valid);
            chk($sformatf("tbl%0d_word", i), cmd_word, tbl[i].word);
        end
        start = 1'b0;
        stop = 1'b0;
        cfg_we = 1'b0;

        // init + calibration + 9 frames, batch of 8, no stalls
        do_reset();
        cfg_write(3, 8'hA5);
        batch_len = 16'd8;
        fast_settle = 1'b0;
        do_start();
        collect(PRE + FLEN * 9, 0);
        build_exp(9, 32'h0);
        cmp_stream("nostall");
        cmp_pulses("nostall", 8, 9);
        chk("init_w3", got[3], 16'h83A5);
        chk("first_run", got[PRE], 16'h0000);
        chk("aux_f0", got[PRE + NCH + 1], 16'hE800);
        chk("aux_f4", got[PRE + FLEN * 4 + NCH + 1], 16'hEC00);
        chk("aux_f5", got[PRE + FLEN * 5 + NCH + 1], 16'hE800);

        // same run with random stalls must give the identical word list
        do_reset();
        cfg_write(3, 8'hA5);
        do_start();
        collect(PRE + FLEN * 9, 40);
        build_exp(9, 32'h0);
        cmp_stream("stall");
        cmp_pulses("stall", 8, 9);

        // fast_settle folded into bit 5 of the slot NCH write
        do_reset();
        cfg_write(0, 8'hDE);
        fast_settle = 1'b1;
        do_start();
        collect(PRE + FLEN, 0);
        fast_settle = 1'b0;
        collect(FLEN, 0);
        build_exp(2, 32'h1);
        cmp_stream("fsettle");
        chk("fs_on", got[PRE + NCH], 16'h80FE);
        chk("fs_off", got[PRE + FLEN + NCH], 16'h80DE);

        // stop while RUN slot 10 is presented
        do_reset();
        do_start();
        collect(PRE + 10, 0);
        stop = 1'b1;
        drain(n);
        chk("stop_tail_words", n, 25);
        build_exp(1, 32'h0);
        cmp_stream("stop_run");
        chk("stop_busy_1", busy, 1'b1);
        chk("stop_valid_1", cmd_valid, 1'b0);
        @(negedge aclk);
        chk("stop_busy_2", busy, 1'b0);
        chk("stop_valid_2", cmd_valid, 1'b0);

        // stop during INIT waits for the first full RUN frame
        do_reset();
        do_start();
        stop = 1'b1;
        drain(n);
        chk("stop_init_words", n, PRE + FLEN);
        build_exp(1, 32'h0);
        cmp_stream("stop_init");
        @(negedge aclk);
        chk("stop_init_busy", busy, 1'b0);

        // batch_len lowered below the running count mid-frame
        do_reset();
        batch_len = 16'd8;
        do_start();
        collect(PRE + FLEN * 3 + 5, 0);
        batch_len = 16'd2;
        collect(FLEN * 3 - 5, 0);
        eb.delete();
        eb.push_back(PRE + FLEN * 4);
        eb.push_back(PRE + FLEN * 6);
        cmp_q("blen_drop", bd_at, eb);

        // asynchronous reset while calibrating
        do_reset();
        cfg_write(3, 8'hA5);
        do_start();
        collect(10, 0);
        aresetn = 1'b0;
        #1;
        chk("async_valid", cmd_valid, 1'b0);
        chk("async_word", cmd_word, 16'h0000);
        chk("async_busy", busy, 1'b0);
        chk("async_fstart", frame_start, 1'b0);
        chk("async_bdone", batch_done, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        cmd_ready = 1'b0;
        for (int i = 0; i < 8; i++) sh[i] = 8'h00;
        @(negedge aclk);
        @(negedge aclk);
        chk("no_autostart_busy", busy, 1'b0);
        chk("no_autostart_valid", cmd_valid, 1'b0);
        do_start();
        chk("restart_word", cmd_word, 16'h8000);
        collect(PRE + 1, 0);
        build_exp(1, 32'h0);
        exp_q = exp_q[0:PRE];
        cmp_stream("restart");

        // randomized shadow, fast_settle, batch length and stalls
        for (int t = 0; t < 3; t++) begin
            do_reset();
            for (int r = 0; r < 8; r++) cfg_write(r, 8'($urandom));
            fs = 1'($urandom_range(0, 1));
            len = int'($urandom_range(0, 3));
            fast_settle = fs;
            batch_len = 16'(len);
            do_start();
            collect(PRE + FLEN * 6, 35);
            build_exp(6, {32{fs}});
            cmp_stream($sformatf("rand%0d", t));
            cmp_pulses($sformatf("rand%0d", t), (len == 0) ? 1 : len, 6);
        end
        cmd_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
